// File: rtl/rfphoenix_pte_amupd.sv
// PTE accessed/modified write-back engine.
// Queues {PTE address, set-m} updates from the TLB, merges duplicates that are
// still waiting, and performs a locked 32-bit read-modify-write per entry on a
// Wishbone-style bus (cyc held from read through write).
module rfphoenix_pte_amupd #(
    parameter int QDEP = 4,
    parameter int AWID = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    input  logic [AWID-1:0] req_adr_i,
    input  logic            req_m_i,
    output logic            req_rdy_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [3:0]      sel_o,
    output logic [AWID-1:0] adr_o,
    output logic [31:0]     dat_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic [31:0]     dat_i,
    output logic            busy_o,
    output logic            err_o,
    output logic [AWID-1:0] err_adr_o
);

    localparam int PW = $clog2(QDEP);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_WR,
        S_WRW
    } state_t;

    // Queue storage: one register slot per entry so every slot can be compared
    // against an incoming address in the same cycle.
    logic [AWID-1:0] q_adr_q [QDEP];
    logic            q_m_q   [QDEP];
    logic            q_vld_q [QDEP];

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rdy_q, rdy_d;

    state_t          state_q, state_d;
    logic [AWID-1:0] adr_r_q, adr_r_d;
    logic            m_r_q, m_r_d;
    logic [31:0]     dat_q, dat_d;
    logic            err_q, err_d;
    logic [AWID-1:0] err_adr_q, err_adr_d;

    logic [AWID-1:0] req_adr_al;
    logic [QDEP-1:0] hit;
    logic            pop;
    logic            merge;
    logic            push;
    logic [31:0]     pte_new;

    // PTEs are word aligned; the two low address bits are never used.
    assign req_adr_al = {req_adr_i[AWID-1:2], 2'b00};

    // The head leaves the queue whenever the engine is idle and work exists.
    assign pop = (state_q == S_IDLE) && (cnt_q != '0);

    // A slot matches only while it is still waiting; the head being popped this
    // cycle is excluded so a late merge cannot be lost on its way out.
    for (genvar gi = 0; gi < QDEP; gi++) begin : g_hit
        assign hit[gi] = q_vld_q[gi] && (q_adr_q[gi] == req_adr_al) &&
                         !(pop && (rd_ptr_q == PW'(gi)));
    end

    // Merges need no free slot, so they are taken even while the queue is full.
    assign merge = req_i && (|hit);
    assign push  = req_i && rdy_q && !merge;

    // Per-slot state: allocate on push, release on pop, OR in m on merge.
    for (genvar gi = 0; gi < QDEP; gi++) begin : g_slot
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                q_vld_q[gi] <= 1'b0;
                q_adr_q[gi] <= '0;
                q_m_q[gi]   <= 1'b0;
            end else begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    q_vld_q[gi] <= 1'b1;
                    q_adr_q[gi] <= req_adr_al;
                    q_m_q[gi]   <= req_m_i;
                end else if (pop && (rd_ptr_q == PW'(gi))) begin
                    q_vld_q[gi] <= 1'b0;
                end
                if (merge && hit[gi]) begin
                    q_m_q[gi] <= q_m_q[gi] | req_m_i;
                end
            end
        end
    end

    // Pointer/count bookkeeping; ready is registered from the next count.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        rdy_d    = (cnt_d != CW'(QDEP));
    end

    // Queue control registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
        end
    end

    // Updated PTE: a always set, m set when the request asked for it.
    assign pte_new = dat_i | 32'h0000_0200 | {21'd0, m_r_q, 10'd0};

    // Bus FSM next-state logic.
    always_comb begin
        state_d   = state_q;
        adr_r_d   = adr_r_q;
        m_r_d     = m_r_q;
        dat_d     = dat_q;
        err_d     = 1'b0;
        err_adr_d = err_adr_q;
        case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    adr_r_d = q_adr_q[rd_ptr_q];
                    m_r_d   = q_m_q[rd_ptr_q];
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_RDW;
            end
            S_RDW: begin
                if (err_i) begin
                    err_d     = 1'b1;
                    err_adr_d = adr_r_q;
                    state_d   = S_IDLE;
                end else if (ack_i) begin
                    // Invalid PTE or nothing to change: skip the write.
                    if (!dat_i[0] || (pte_new == dat_i)) begin
                        state_d = S_IDLE;
                    end else begin
                        dat_d   = pte_new;
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                state_d = S_WRW;
            end
            S_WRW: begin
                if (err_i) begin
                    err_d     = 1'b1;
                    err_adr_d = adr_r_q;
                    state_d   = S_IDLE;
                end else if (ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            adr_r_q   <= '0;
            m_r_q     <= 1'b0;
            dat_q     <= '0;
            err_q     <= 1'b0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            adr_r_q   <= adr_r_d;
            m_r_q     <= m_r_d;
            dat_q     <= dat_d;
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
        end
    end

    // Bus outputs decode straight from state so reset drops the cycle at once.
    assign cyc_o     = (state_q != S_IDLE);
    assign stb_o     = (state_q != S_IDLE);
    assign we_o      = (state_q == S_WR) || (state_q == S_WRW);
    assign sel_o     = stb_o ? 4'hF : 4'h0;
    assign adr_o     = adr_r_q;
    assign dat_o     = dat_q;
    assign req_rdy_o = rdy_q;
    assign busy_o    = (cnt_q != '0) || (state_q != S_IDLE);
    assign err_o     = err_q;
    assign err_adr_o = err_adr_q;

endmodule

// File: tb/tb_rfphoenix_pte_amupd.sv
// Bench for the PTE A/M write-back engine: a table of single-request vectors
// followed by hand-written merge, queue-full, bus-error and reset sequences.
module tb_rfphoenix_pte_amupd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] req_adr_i = '0;
    logic        req_m_i = 1'b0;
    logic        req_rdy_o, cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic [31:0] dat_i = '0;
    logic        busy_o, err_o;
    logic [31:0] err_adr_o;

    always #5 clk = ~clk;

    rfphoenix_pte_amupd #(.QDEP(4), .AWID(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req_i), .req_adr_i(req_adr_i), .req_m_i(req_m_i), .req_rdy_o(req_rdy_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
        .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
        .busy_o(busy_o), .err_o(err_o), .err_adr_o(err_adr_o)
    );

    typedef struct {
        logic [31:0] adr;
        logic        m;
        logic [31:0] rd;
        logic        wr;
        logic [31:0] aadr;
        logic [31:0] wdat;
    } vec_t;

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        gap;
    } bus_t;

    vec_t        vt [8];
    bus_t        blog [$];
    bus_t        ent;
    logic [31:0] mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          scnt = 0;
    int          err_pulses = 0;
    int          err_wide = 0;
    logic        err_prev = 1'b0;
    logic [31:0] err_adr_seen = '0;
    logic        cyc_gap = 1'b1;
    logic        stall_all = 1'b0;
    logic        stall_wr = 1'b0;
    logic [31:0] err_adr_tb = 32'hFFFF_FFFC;

    // Initial PTE content: table vectors define their own, everything else is a
    // valid PTE with a and m clear.
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        for (int i = 0; i < 8; i++) if (vt[i].aadr == a) return vt[i].rd;
        return 32'h0000_0001;
    endfunction

    // Bus slave with one wait state, plus err_o monitor; logs every transaction.
    always @(negedge clk) begin
        if (!cyc_o) cyc_gap = 1'b1;
        if (!rst_n) begin
            ack_i = 1'b0; err_i = 1'b0; dat_i = '0; scnt = 0;
        end else if (ack_i || err_i) begin
            ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
            scnt = stb_o ? 1 : 0;
        end else if (stb_o) begin
            scnt++;
            if (scnt >= 2 && !stall_all && !(we_o && stall_wr)) begin
                ent.we = we_o; ent.adr = adr_o; ent.sel = sel_o; ent.gap = cyc_gap; ent.err = 1'b0;
                if (we_o) begin
                    ent.dat = dat_o;
                    mem[adr_o] = dat_o;
                    ack_i = 1'b1;
                end else begin
                    ent.dat = rd_val(adr_o);
                    cyc_gap = 1'b0;
                    if (adr_o == err_adr_tb) begin
                        err_i = 1'b1; ent.err = 1'b1;
                    end else begin
                        ack_i = 1'b1; dat_i = ent.dat;
                    end
                end
                blog.push_back(ent);
                $display("bus %s adr=%h dat=%h sel=%h err=%b", ent.we ? "WR" : "RD",
                         ent.adr, ent.dat, ent.sel, ent.err);
            end
        end else begin
            scnt = 0;
        end
        if (err_o) begin
            err_pulses++;
            err_adr_seen = err_adr_o;
            if (err_prev) err_wide++;
        end
        err_prev = err_o;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic m);
        int n;
        n = 0;
        @(negedge clk);
        req_i = 1'b1; req_adr_i = a; req_m_i = m;
        while (!req_rdy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL push_%h: req_rdy_o=%b expected 1 within 200 cycles", a, req_rdy_o);
        end
        @(posedge clk);
        #1;
        req_i = 1'b0;
        $display("push adr=%h m=%b", a, m);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_o || cyc_o) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s_timeout: busy_o=%b expected 0", nm, busy_o);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, e0;
        vt[0] = '{32'h0000_1000, 1'b0, 32'h0000_0001, 1'b1, 32'h0000_1000, 32'h0000_0201};
        vt[1] = '{32'h0000_1004, 1'b1, 32'h0000_0601, 1'b0, 32'h0000_1004, 32'h0};
        vt[2] = '{32'h0000_1008, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_1008, 32'h0};
        vt[3] = '{32'h0000_100C, 1'b1, 32'h0000_0001, 1'b1, 32'h0000_100C, 32'h0000_0601};
        vt[4] = '{32'h0000_1013, 1'b0, 32'hFFFF_E001, 1'b1, 32'h0000_1010, 32'hFFFF_E201};
        vt[5] = '{32'h0000_1014, 1'b1, 32'h0000_0201, 1'b1, 32'h0000_1014, 32'h0000_0601};
        vt[6] = '{32'h0000_1018, 1'b0, 32'h0000_0401, 1'b1, 32'h0000_1018, 32'h0000_0601};
        vt[7] = '{32'h0000_101C, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_101C, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_rdy", 32'(req_rdy_o), 32'd1);
        chk("rst_cyc", 32'(cyc_o), 32'd0);
        chk("rst_stb", 32'(stb_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_adr", adr_o, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_err_adr", err_adr_o, 32'd0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-request vectors
        for (int i = 0; i < 8; i++) begin
            b = blog.size();
            e0 = err_pulses;
            push(vt[i].adr, vt[i].m);
            wait_idle($sformatf("v%0d", i));
            chk($sformatf("v%0d_ntxn", i), 32'(blog.size() - b), vt[i].wr ? 32'd2 : 32'd1);
            if (blog.size() > b) begin
                chk($sformatf("v%0d_rd_we", i), 32'(blog[b].we), 32'd0);
                chk($sformatf("v%0d_rd_adr", i), blog[b].adr, vt[i].aadr);
            end
            if (vt[i].wr && blog.size() > b + 1) begin
                chk($sformatf("v%0d_wr_we", i), 32'(blog[b+1].we), 32'd1);
                chk($sformatf("v%0d_wr_adr", i), blog[b+1].adr, vt[i].aadr);
                chk($sformatf("v%0d_wr_dat", i), blog[b+1].dat, vt[i].wdat);
                chk($sformatf("v%0d_wr_sel", i), 32'(blog[b+1].sel), 32'hF);
                chk($sformatf("v%0d_cyc_gap", i), 32'(blog[b+1].gap), 32'd0);
            end
            chk($sformatf("v%0d_err_pulses", i), 32'(err_pulses - e0), 32'd0);
            chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'd0);
        end

        // Merge into a waiting entry; same address as in-flight queues normally
        b = blog.size();
        stall_all = 1'b1;
        push(32'h0000_4000, 1'b0);
        push(32'h0000_2000, 1'b0);
        push(32'h0000_2000, 1'b1);
        push(32'h0000_4000, 1'b1);
        stall_all = 1'b0;
        wait_idle("merge");
        chk("merge_ntxn", 32'(blog.size() - b), 32'd6);
        if (blog.size() >= b + 6) begin
            chk("merge_r0_adr", blog[b].adr, 32'h0000_4000);
            chk("merge_w0_dat", blog[b+1].dat, 32'h0000_0201);
            chk("merge_r1_adr", blog[b+2].adr, 32'h0000_2000);
            chk("merge_w1_adr", blog[b+3].adr, 32'h0000_2000);
            chk("merge_w1_dat", blog[b+3].dat, 32'h0000_0601);
            chk("merge_r2_adr", blog[b+4].adr, 32'h0000_4000);
            chk("merge_w2_dat", blog[b+5].dat, 32'h0000_0601);
        end

        // Queue full: 4 queued + 1 in flight, merge still taken, new address refused
        b = blog.size();
        stall_all = 1'b1;
        for (int k = 0; k < 5; k++) push(32'h0000_5000 + 32'(4 * k), 1'b0);
        @(negedge clk);
        chk("full_rdy", 32'(req_rdy_o), 32'd0);
        chk("full_busy", 32'(busy_o), 32'd1);
        req_i = 1'b1; req_adr_i = 32'h0000_5010; req_m_i = 1'b1;
        @(posedge clk);
        #1 req_i = 1'b0;
        $display("push adr=00005010 m=1 (merge while full)");
        @(negedge clk);
        req_i = 1'b1; req_adr_i = 32'h0000_6000; req_m_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("full_rdy_hold", 32'(req_rdy_o), 32'd0);
        req_i = 1'b0;
        stall_all = 1'b0;
        wait_idle("full");
        chk("full_ntxn", 32'(blog.size() - b), 32'd10);
        if (blog.size() >= b + 10) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("full_r%0d_adr", k), blog[b+2*k].adr, 32'h0000_5000 + 32'(4 * k));
                chk($sformatf("full_w%0d_dat", k), blog[b+2*k+1].dat,
                    (k == 4) ? 32'h0000_0601 : 32'h0000_0201);
            end
        end
        chk("full_rdy_back", 32'(req_rdy_o), 32'd1);

        // Bus error on read, next entry proceeds
        b = blog.size();
        e0 = err_pulses;
        err_adr_tb = 32'h0000_3000;
        push(32'h0000_3000, 1'b0);
        push(32'h0000_3004, 1'b0);
        wait_idle("err");
        chk("err_pulses", 32'(err_pulses - e0), 32'd1);
        chk("err_width", 32'(err_wide), 32'd0);
        chk("err_adr_seen", err_adr_seen, 32'h0000_3000);
        chk("err_adr_held", err_adr_o, 32'h0000_3000);
        chk("err_ntxn", 32'(blog.size() - b), 32'd3);
        if (blog.size() >= b + 3) begin
            chk("err_r0_err", 32'(blog[b].err), 32'd1);
            chk("err_r1_adr", blog[b+1].adr, 32'h0000_3004);
            chk("err_w1_we", 32'(blog[b+2].we), 32'd1);
            chk("err_w1_dat", blog[b+2].dat, 32'h0000_0201);
        end

        // Reset in the middle of a stalled write with another entry queued
        stall_wr = 1'b1;
        push(32'h0000_7000, 1'b0);
        push(32'h0000_7004, 1'b0);
        begin
            int n;
            n = 0;
            while (!we_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("rstmid_reach_wr", 32'(we_o), 32'd1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_cyc", 32'(cyc_o), 32'd0);
        chk("rstmid_stb", 32'(stb_o), 32'd0);
        chk("rstmid_we", 32'(we_o), 32'd0);
        chk("rstmid_busy", 32'(busy_o), 32'd0);
        chk("rstmid_rdy", 32'(req_rdy_o), 32'd1);
        chk("rstmid_err_adr", err_adr_o, 32'd0);
        stall_wr = 1'b0;
        b = blog.size();
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstmid_no_txn", 32'(blog.size() - b), 32'd0);
        chk("rstmid_idle", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
